sync_fifo_hs: RTL and testbench

Single-clock, register-based synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through read data, arbitrary (non-power-of-2) depth, runtime-programmable almost-full/almost-empty thresholds, synchronous flush, a sticky overflow flag and a high-water-mark monitor. It is the next-generation drop-in buffer for streaming datapaths where producer and consumer share `clk`. Status outputs derive directly from registered state, with no extra latency.

---
 rtl/sync_fifo_hs_if.sv | 32 +++
 rtl/sync_fifo_hs.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_hs.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_hs_if.sv
// Valid/ready handshake bundle for sync_fifo_hs: a write channel into the FIFO and a
// first-word-fall-through read channel out of it.
interface sync_fifo_hs_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              i_wr_valid;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              i_rd_ready;

    // FIFO side
    modport slave (
        input  i_wr_valid,
        input  i_wr_data,
        input  i_rd_ready,
        output o_wr_ready,
        output o_rd_valid,
        output o_rd_data
    );

    // Producer/consumer side
    modport master (
        output i_wr_valid,
        output i_wr_data,
        output i_rd_ready,
        input  o_wr_ready,
        input  o_rd_valid,
        input  o_rd_data
    );
endinterface

// File: rtl/sync_fifo_hs.sv
// Single-clock register FIFO with valid/ready on both sides, FWFT read data, arbitrary
// depth, live almost-full/empty thresholds, flush, sticky overflow and high-water mark.
module sync_fifo_hs #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    sync_fifo_hs_if.slave    bus,
    input  logic             i_flush,
    input  logic             i_clr_stat,
    input  logic [CNT_W-1:0] i_afull_th,
    input  logic [CNT_W-1:0] i_aempty_th,
    output logic [CNT_W-1:0] o_level,
    output logic             o_afull,
    output logic             o_aempty,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_peak
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // INIT holds off writes for one cycle after reset release
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wrptr_q, wrptr_d;
    logic [PTR_W-1:0]   rdptr_q, rdptr_d;
    logic [CNT_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   peak_q, peak_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic init_done;
    logic full;
    logic empty;
    logic wr_ready;
    logic rd_valid;
    logic wr_acc;
    logic rd_acc;
    logic ovf_set;

    assign init_done = (state_q == ST_RUN);
    assign full      = (level_q == DEPTH_C);
    assign empty     = (level_q == '0);
    assign wr_ready  = init_done & ~full & ~i_flush;
    assign rd_valid  = ~empty & ~i_flush;
    assign wr_acc    = bus.i_wr_valid & wr_ready;
    assign rd_acc    = rd_valid & bus.i_rd_ready;
    assign ovf_set   = init_done & bus.i_wr_valid & full & ~i_flush;

    // Next-state: init sequencing, pointers, occupancy and statistics
    always_comb begin
        state_d = state_q;
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        peak_d  = peak_q;

        if (state_q == ST_INIT) begin
            state_d = ST_RUN;
        end

        if (i_flush) begin
            wrptr_d = '0;
            rdptr_d = '0;
            level_d = '0;
        end else begin
            if (wr_acc) begin
                wrptr_d = (wrptr_q == LAST_PTR) ? '0 : wrptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rdptr_d = (rdptr_q == LAST_PTR) ? '0 : rdptr_q + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - CNT_W'(1);
            end
        end

        // A coincident overflow outranks the clear
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (i_clr_stat) begin
            ovf_d = 1'b0;
        end

        if (i_clr_stat || (level_d > peak_q)) begin
            peak_d = level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_INIT;
            wrptr_q <= '0;
            rdptr_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            peak_q  <= peak_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wrptr_q] <= bus.i_wr_data;
        end
    end

    assign bus.o_wr_ready = wr_ready;
    assign bus.o_rd_valid = rd_valid;
    assign bus.o_rd_data  = mem_q[rdptr_q];

    assign o_level  = level_q;
    assign o_full   = full;
    assign o_empty  = empty;
    assign o_afull  = (level_q >= i_afull_th) | ~init_done;
    assign o_aempty = (level_q <= i_aempty_th);
    assign o_ovf    = ovf_q;
    assign o_peak   = peak_q;

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Directed bench for sync_fifo_hs (DEPTH=12): init cycle, fill/drain with wrap, full+read,
// flush, stat clear, steady streaming, live thresholds and mid-operation reset.
module tb_sync_fifo_hs;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 12;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn;
    logic             i_flush;
    logic             i_clr_stat;
    logic [CNT_W-1:0] i_afull_th;
    logic [CNT_W-1:0] i_aempty_th;
    logic [CNT_W-1:0] o_level;
    logic             o_afull;
    logic             o_aempty;
    logic             o_full;
    logic             o_empty;
    logic             o_ovf;
    logic [CNT_W-1:0] o_peak;

    sync_fifo_hs_if #(.DATA_W(DATA_W)) bus ();

    sync_fifo_hs #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .i_flush    (i_flush),
        .i_clr_stat (i_clr_stat),
        .i_afull_th (i_afull_th),
        .i_aempty_th(i_aempty_th),
        .o_level    (o_level),
        .o_afull    (o_afull),
        .o_aempty   (o_aempty),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_ovf      (o_ovf),
        .o_peak     (o_peak)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns 2 time units after the rising edge, well clear of it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One cycle of traffic with the expected accept outcome for each side
    task automatic xfer(input logic wv, input logic [DATA_W-1:0] wd, input logic rr,
                        input logic ew, input logic er);
        bus.i_wr_valid = wv;
        bus.i_wr_data  = wd;
        bus.i_rd_ready = rr;
        #1;
        chk("wr_accept", 32'(wv & bus.o_wr_ready), 32'(ew));
        chk("rd_accept", 32'(bus.o_rd_valid & rr), 32'(er));
        if (er && exp_q.size() > 0) chk("rd_data", 32'(bus.o_rd_data), 32'(exp_q[0]));
        tick();
        if (ew) exp_q.push_back(wd);
        if (er && exp_q.size() > 0) void'(exp_q.pop_front());
        chk("level", 32'(o_level), 32'(exp_q.size()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn           = 1'b0;
        i_flush        = 1'b0;
        i_clr_stat     = 1'b0;
        i_afull_th     = 4'd10;
        i_aempty_th    = 4'd2;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;
        repeat (3) tick();

        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        chk("rst_afull", 32'(o_afull), 32'd1);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_peak", 32'(o_peak), 32'd0);

        // Release reset with a write already pending: refused during the init cycle
        rstn           = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'h01;
        #1;
        chk("init_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        chk("init_afull", 32'(o_afull), 32'd1);
        chk("init_empty", 32'(o_empty), 32'd1);
        chk("init_aempty", 32'(o_aempty), 32'd1);
        tick();
        chk("run_wr_ready", 32'(bus.o_wr_ready), 32'd1);
        chk("run_afull", 32'(o_afull), 32'd0);
        chk("run_empty", 32'(o_empty), 32'd1);
        chk("run_aempty", 32'(o_aempty), 32'd1);

        // First fill 0x01..0x0C
        for (int i = 1; i <= 12; i++) xfer(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        bus.i_wr_valid = 1'b0;
        #1;
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        chk("fill_afull", 32'(o_afull), 32'd1);
        chk("fill_peak", 32'(o_peak), 32'd12);
        chk("fill_ovf", 32'(o_ovf), 32'd0);

        for (int i = 0; i < 12; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        bus.i_rd_ready = 1'b0;
        #1;
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("drain_rd_valid", 32'(bus.o_rd_valid), 32'd0);

        // Second fill exercises pointer wrap
        for (int i = 0; i < 12; i++) xfer(1'b1, 8'(8'h21 + i), 1'b0, 1'b1, 1'b0);
        bus.i_wr_valid = 1'b0;
        #1;
        chk("refill_full", 32'(o_full), 32'd1);

        // Full with simultaneous read: read taken, write refused, overflow flagged
        xfer(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        chk("fullrd_ovf", 32'(o_ovf), 32'd1);
        chk("fullrd_wr_ready", 32'(bus.o_wr_ready), 32'd1);
        xfer(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        chk("fullrd_full", 32'(o_full), 32'd1);

        // Stat clear coinciding with another overflow: the set wins
        i_clr_stat = 1'b1;
        xfer(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        i_clr_stat     = 1'b0;
        bus.i_wr_valid = 1'b0;
        chk("setwins_ovf", 32'(o_ovf), 32'd1);
        chk("setwins_peak", 32'(o_peak), 32'd12);

        for (int i = 0; i < 5; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Flush at level 7 with both sides requesting
        i_flush        = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'hCC;
        bus.i_rd_ready = 1'b1;
        #1;
        chk("flush_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        chk("flush_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        tick();
        i_flush        = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_rd_ready = 1'b0;
        exp_q.delete();
        chk("flush_level", 32'(o_level), 32'd0);
        chk("flush_empty", 32'(o_empty), 32'd1);
        chk("flush_ovf_kept", 32'(o_ovf), 32'd1);
        chk("flush_peak_kept", 32'(o_peak), 32'd12);

        i_clr_stat = 1'b1;
        tick();
        i_clr_stat = 1'b0;
        chk("clr_ovf", 32'(o_ovf), 32'd0);
        chk("clr_peak", 32'(o_peak), 32'd0);

        // Steady stream at level 5
        for (int i = 0; i < 5; i++) xfer(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) xfer(1'b1, 8'(8'h50 + i), 1'b1, 1'b1, 1'b1);
        chk("stream_peak", 32'(o_peak), 32'd5);

        // Thresholds are live comparisons against level
        for (int i = 0; i < 3; i++) xfer(1'b1, 8'(8'h70 + i), 1'b0, 1'b1, 1'b0);
        bus.i_wr_valid = 1'b0;
        i_afull_th     = 4'd8;
        #1;
        chk("th_afull_8", 32'(o_afull), 32'd1);
        i_afull_th = 4'd9;
        #1;
        chk("th_afull_9", 32'(o_afull), 32'd0);
        chk("th_aempty_l8", 32'(o_aempty), 32'd0);
        for (int i = 0; i < 5; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("th_aempty_l3", 32'(o_aempty), 32'd0);
        xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("th_aempty_l2", 32'(o_aempty), 32'd1);
        bus.i_rd_ready = 1'b0;

        // Reset mid-operation discards contents and statistics
        rstn = 1'b0;
        tick();
        exp_q.delete();
        chk("mrst_level", 32'(o_level), 32'd0);
        chk("mrst_empty", 32'(o_empty), 32'd1);
        chk("mrst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        chk("mrst_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        chk("mrst_peak", 32'(o_peak), 32'd0);
        chk("mrst_afull", 32'(o_afull), 32'd1);
        rstn           = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'h99;
        #1;
        chk("mrst_init_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        tick();
        xfer(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        bus.i_rd_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
